// File: rtl/mu0_arb_mux.sv
// mu0_arb_mux: N-channel registered arbitrating mux (fixed priority or round robin).
// One output register stage; a draining word can be replaced in the same cycle.
module mu0_arb_mux #(
    parameter int WIDTH = 12,
    parameter int CH    = 2,
    parameter int MODE  = 0,
    parameter int SELW  = $clog2(CH)
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [CH*WIDTH-1:0] In_data,
    input  logic [CH-1:0]       In_valid,
    output logic [CH-1:0]       In_ready,
    input  logic                Hold,
    output logic [WIDTH-1:0]    Out_data,
    output logic                Out_valid,
    output logic [SELW-1:0]     Out_sel,
    input  logic                Out_ready
);
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SELW-1:0]  r_sel;
    logic [SELW-1:0]  r_ptr;
    logic [SELW-1:0]  r_last;
    logic             w_load_en;
    logic             w_found;
    logic             w_xfer;
    logic [SELW-1:0]  w_gidx;
    logic [SELW-1:0]  w_lo_all;
    logic [SELW-1:0]  w_lo_hi;
    logic [CH-1:0]    w_hi;
    logic [WIDTH-1:0] w_gdata;

    assign w_load_en = !r_valid || Out_ready;
    // Channels at or above the pointer win before wrapping; ptr stays 0 in fixed-priority mode.
    assign w_hi = In_valid & ~((CH'(1) << r_ptr) - CH'(1));

    always_comb begin
        w_lo_all = '0;
        w_lo_hi  = '0;
        w_gdata  = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (In_valid[i]) w_lo_all = SELW'(i);
            if (w_hi[i]) w_lo_hi = SELW'(i);
        end
        w_found = |In_valid;
        w_gidx  = (Hold && In_valid[r_last]) ? r_last : (|w_hi) ? w_lo_hi : w_lo_all;
        for (int i = 0; i < CH; i++)
            if (w_gidx == SELW'(i)) w_gdata = In_data[i*WIDTH +: WIDTH];
    end

    assign w_xfer   = w_load_en && w_found;
    assign In_ready = (Reset_n && w_xfer) ? (CH'(1) << w_gidx) : '0;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_last  <= '0;
        end else if (w_xfer) begin
            r_data  <= w_gdata;
            r_valid <= 1'b1;
            r_sel   <= w_gidx;
            r_last  <= w_gidx;
            if (MODE == 1) r_ptr <= (w_gidx == SELW'(CH - 1)) ? '0 : w_gidx + 1'b1;
        end else if (Out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign Out_data  = r_data;
    assign Out_valid = r_valid;
    assign Out_sel   = r_sel;
endmodule

// File: tb/tb_mu0_arb_mux.sv
// tb_mu0_arb_mux: directed checks of mu0_arb_mux across fixed-priority, round-robin
// and narrow/wide configurations, with hand-computed expectations.
module tb_mu0_arb_mux;
    logic        Clk;
    logic        Reset_n;
    int          checks;
    int          errors;

    logic [47:0] a_data;
    logic [3:0]  a_valid, a_irdy;
    logic        a_hold, a_ovalid, a_ordy;
    logic [11:0] a_odata;
    logic [1:0]  a_osel;

    logic [47:0] b_data;
    logic [3:0]  b_valid, b_irdy;
    logic        b_hold, b_ovalid, b_ordy;
    logic [11:0] b_odata;
    logic [1:0]  b_osel;

    logic [1:0]  c_data, c_valid, c_irdy;
    logic        c_hold, c_ovalid, c_ordy;
    logic [0:0]  c_odata, c_osel;

    logic [95:0] d_data;
    logic [2:0]  d_valid, d_irdy;
    logic        d_hold, d_ovalid, d_ordy;
    logic [31:0] d_odata;
    logic [1:0]  d_osel;

    mu0_arb_mux #(.WIDTH(12), .CH(4), .MODE(0)) u_fp (
        .Clk(Clk), .Reset_n(Reset_n), .In_data(a_data), .In_valid(a_valid), .In_ready(a_irdy),
        .Hold(a_hold), .Out_data(a_odata), .Out_valid(a_ovalid), .Out_sel(a_osel), .Out_ready(a_ordy));
    mu0_arb_mux #(.WIDTH(12), .CH(4), .MODE(1)) u_rr (
        .Clk(Clk), .Reset_n(Reset_n), .In_data(b_data), .In_valid(b_valid), .In_ready(b_irdy),
        .Hold(b_hold), .Out_data(b_odata), .Out_valid(b_ovalid), .Out_sel(b_osel), .Out_ready(b_ordy));
    mu0_arb_mux #(.WIDTH(1), .CH(2), .MODE(1)) u_w1 (
        .Clk(Clk), .Reset_n(Reset_n), .In_data(c_data), .In_valid(c_valid), .In_ready(c_irdy),
        .Hold(c_hold), .Out_data(c_odata), .Out_valid(c_ovalid), .Out_sel(c_osel), .Out_ready(c_ordy));
    mu0_arb_mux #(.WIDTH(32), .CH(3), .MODE(1)) u_w32 (
        .Clk(Clk), .Reset_n(Reset_n), .In_data(d_data), .In_valid(d_valid), .In_ready(d_irdy),
        .Hold(d_hold), .Out_data(d_odata), .Out_valid(d_ovalid), .Out_sel(d_osel), .Out_ready(d_ordy));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 4'b0100;
        a_data  = {12'h0, 12'h321, 12'h0, 12'h0};
        a_ordy  = 1'b0;
        tick();
        checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL rst_preload_valid got %b exp 1", a_ovalid); end
        checks++; if (a_osel !== 2'd2) begin errors++; $display("FAIL rst_preload_sel got %0d exp 2", a_osel); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", a_ovalid); end
        checks++; if (a_odata !== 12'h000) begin errors++; $display("FAIL rst_data got %h exp 000", a_odata); end
        checks++; if (a_osel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", a_osel); end
        checks++; if (a_irdy !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got %b exp 0000", a_irdy); end
        tick();
        Reset_n = 1'b1;
        a_valid = 4'b0000;
        a_ordy  = 1'b1;
        tick();
    endtask

    task automatic test_fixed_priority();
        a_ordy  = 1'b1;
        a_valid = 4'b1010;
        a_data  = {12'hFFF, 12'h0, 12'h0A5, 12'h0};
        #1;
        checks++; if (a_irdy !== 4'b0010) begin errors++; $display("FAIL fp_in_ready got %b exp 0010", a_irdy); end
        tick();
        checks++; if (a_odata !== 12'h0A5) begin errors++; $display("FAIL fp_data got %h exp 0a5", a_odata); end
        checks++; if (a_osel !== 2'd1) begin errors++; $display("FAIL fp_sel got %0d exp 1", a_osel); end
        checks++; if (a_irdy !== 4'b0010) begin errors++; $display("FAIL fp_ch1_again got %b exp 0010", a_irdy); end
        a_valid = 4'b1000;
        #1;
        checks++; if (a_irdy !== 4'b1000) begin errors++; $display("FAIL fp_ch3_ready got %b exp 1000", a_irdy); end
        tick();
        checks++; if (a_odata !== 12'hFFF || a_osel !== 2'd3) begin errors++; $display("FAIL fp_ch3 got %h/%0d exp fff/3", a_odata, a_osel); end
        a_valid = 4'b0000;
        tick();
        checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL fp_drain_valid got %b exp 0", a_ovalid); end
        checks++; if (a_odata !== 12'hFFF) begin errors++; $display("FAIL fp_drain_keep got %h exp fff", a_odata); end
    endtask

    task automatic test_stall();
        a_ordy  = 1'b1;
        a_valid = 4'b0001;
        a_data  = {12'h0, 12'h0, 12'h0, 12'h123};
        tick();
        a_ordy  = 1'b0;
        a_valid = 4'b0101;
        a_data  = {12'h0, 12'h789, 12'h0, 12'h456};
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (a_irdy !== 4'b0000) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0000", k, a_irdy); end
            tick();
            checks++; if (a_odata !== 12'h123 || a_ovalid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d] got %h/%b exp 123/1", k, a_odata, a_ovalid); end
        end
        a_ordy = 1'b1;
        #1;
        checks++; if (a_irdy !== 4'b0001) begin errors++; $display("FAIL stall_release_ready got %b exp 0001", a_irdy); end
        tick();
        checks++; if (a_odata !== 12'h456 || a_osel !== 2'd0 || a_ovalid !== 1'b1) begin errors++; $display("FAIL stall_reload got %h/%0d/%b exp 456/0/1", a_odata, a_osel, a_ovalid); end
        a_valid = 4'b0000;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_sel;
        b_ordy  = 1'b1;
        b_valid = 4'b1111;
        b_data  = {12'h103, 12'h102, 12'h101, 12'h100};
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_sel = 2'(k % 4);
            checks++; if (b_osel !== exp_sel || b_odata !== 12'h100 + 12'(exp_sel) || b_ovalid !== 1'b1) begin
                errors++; $display("FAIL rr_seq[%0d] got sel %0d data %h valid %b exp sel %0d", k, b_osel, b_odata, b_ovalid, exp_sel);
            end
        end
        b_valid = 4'b0000;
        tick();
    endtask

    task automatic test_hold();
        b_ordy  = 1'b1;
        b_valid = 4'b0101;
        b_hold  = 1'b0;
        #1;
        checks++; if (b_irdy !== 4'b0100) begin errors++; $display("FAIL hold_first_grant got %b exp 0100", b_irdy); end
        tick();
        checks++; if (b_osel !== 2'd2) begin errors++; $display("FAIL hold_first_sel got %0d exp 2", b_osel); end
        b_hold = 1'b1;
        #1;
        checks++; if (b_irdy !== 4'b0100) begin errors++; $display("FAIL hold_regrant got %b exp 0100", b_irdy); end
        tick();
        checks++; if (b_osel !== 2'd2) begin errors++; $display("FAIL hold_sel got %0d exp 2", b_osel); end
        b_hold = 1'b0;
        #1;
        checks++; if (b_irdy !== 4'b0001) begin errors++; $display("FAIL hold_release_grant got %b exp 0001", b_irdy); end
        tick();
        checks++; if (b_osel !== 2'd0) begin errors++; $display("FAIL hold_release_sel got %0d exp 0", b_osel); end
        b_valid = 4'b0000;
        tick();
    endtask

    task automatic test_width_wrap();
        logic [31:0] d_exp [3];
        d_exp[0] = 32'hDEADBEEF;
        d_exp[1] = 32'h80000001;
        d_exp[2] = 32'hFFFFFFFF;
        c_ordy  = 1'b1;
        c_valid = 2'b11;
        c_data  = 2'b10;
        d_ordy  = 1'b1;
        d_valid = 3'b111;
        d_data  = {d_exp[2], d_exp[1], d_exp[0]};
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (c_osel !== 1'(k % 2) || c_odata !== 1'(k % 2)) begin errors++; $display("FAIL w1[%0d] got sel %0d data %b exp %0d", k, c_osel, c_odata, k % 2); end
            checks++; if (d_osel !== 2'(k % 3) || d_odata !== d_exp[k % 3]) begin errors++; $display("FAIL w32[%0d] got sel %0d data %h exp sel %0d data %h", k, d_osel, d_odata, k % 3, d_exp[k % 3]); end
        end
        c_valid = 2'b00;
        d_valid = 3'b000;
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        a_data = '0; a_valid = '0; a_hold = 1'b0; a_ordy = 1'b1;
        b_data = '0; b_valid = '0; b_hold = 1'b0; b_ordy = 1'b1;
        c_data = '0; c_valid = '0; c_hold = 1'b0; c_ordy = 1'b1;
        d_data = '0; d_valid = '0; d_hold = 1'b0; d_ordy = 1'b1;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
        test_reset();
        test_fixed_priority();
        test_stall();
        test_back_to_back();
        test_hold();
        test_width_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
